// File: rtl/decode_stage.sv
// decode_stage: handshaked decode / operand-fetch stage. A per-register scoreboard
// stalls RAW/WAW hazards; writeback data can be bypassed straight into operands.
module decode_stage #(
    parameter int XLEN         = 32,
    parameter int NUM_REGS     = 32,
    parameter int FORWARDING   = 1,
    parameter int ERROR_INJECT = 0,
    localparam int RW          = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              instr,
    input  logic [NUM_REGS*XLEN-1:0] register_bank,
    input  logic                     wb_valid,
    input  logic [RW-1:0]            wb_rd,
    input  logic [XLEN-1:0]          wb_data,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          op1,
    output logic [XLEN-1:0]          op2,
    output logic [XLEN-1:0]          op3,
    output logic [RW-1:0]            rd,
    output logic [31:0]              out_instr,
    output logic                     illegal
);

    localparam logic [6:0]  OPC_LOAD    = 7'h03;
    localparam logic [6:0]  OPC_OP_IMM  = 7'h13;
    localparam logic [6:0]  OPC_AUIPC   = 7'h17;
    localparam logic [6:0]  OPC_STORE   = 7'h23;
    localparam logic [6:0]  OPC_OP      = 7'h33;
    localparam logic [6:0]  OPC_LUI     = 7'h37;
    localparam logic [6:0]  OPC_BRANCH  = 7'h63;
    localparam logic [6:0]  OPC_JALR    = 7'h67;
    localparam logic [6:0]  OPC_JAL     = 7'h6F;
    localparam logic [31:0] EBREAK_WORD = 32'h0010_0073;

    function automatic logic is_r_type(input logic [31:0] i);
        return i[6:0] == OPC_OP;
    endfunction

    // Shift-immediates are OP-IMM with funct3 001/101; imm is the zero-extended shamt.
    function automatic logic is_si_type(input logic [31:0] i);
        return (i[6:0] == OPC_OP_IMM) && (i[13:12] == 2'b01);
    endfunction

    function automatic logic is_i_type(input logic [31:0] i);
        return (i[6:0] == OPC_LOAD) || (i[6:0] == OPC_JALR) ||
               ((i[6:0] == OPC_OP_IMM) && !is_si_type(i));
    endfunction

    function automatic logic is_s_type(input logic [31:0] i);
        return i[6:0] == OPC_STORE;
    endfunction

    function automatic logic is_b_type(input logic [31:0] i);
        return i[6:0] == OPC_BRANCH;
    endfunction

    function automatic logic is_u_type(input logic [31:0] i);
        return (i[6:0] == OPC_LUI) || (i[6:0] == OPC_AUIPC);
    endfunction

    function automatic logic is_j_type(input logic [31:0] i);
        return i[6:0] == OPC_JAL;
    endfunction

    function automatic logic is_ebreak(input logic [31:0] i);
        return i == EBREAK_WORD;
    endfunction

    function automatic logic [RW-1:0] get_rs1(input logic [31:0] i);
        return i[15 +: RW];
    endfunction

    function automatic logic [RW-1:0] get_rs2(input logic [31:0] i);
        return i[20 +: RW];
    endfunction

    function automatic logic [RW-1:0] get_rd(input logic [31:0] i);
        return i[7 +: RW];
    endfunction

    function automatic logic [XLEN-1:0] get_imm(input logic [31:0] i);
        logic [31:0] imm;
        if (is_i_type(i)) begin
            imm = {{20{i[31]}}, i[31:20]};
        end else if (is_si_type(i)) begin
            imm = {27'd0, i[24:20]};
        end else if (is_s_type(i)) begin
            imm = {{20{i[31]}}, i[31:25], i[11:7]};
        end else if (is_b_type(i)) begin
            imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
        end else if (is_u_type(i)) begin
            imm = {i[31:12], 12'd0};
        end else if (is_j_type(i)) begin
            imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
        end else begin
            imm = 32'd0;
        end
        return XLEN'($signed(imm));
    endfunction

    logic                r_s, i_s, si_s, s_s, b_s, u_s, j_s, ebreak_s, illegal_s;
    logic                uses_rs1_s, uses_rs2_s, writes_rd_s;
    logic [RW-1:0]       rs1_s, rs2_s, rd_s;
    logic [XLEN-1:0]     imm_s, rs1_val_s, rs2_val_s;
    logic                fwd1_s, fwd2_s, hazard_s, in_ready_s, accept_s;
    logic [XLEN-1:0]     op1_cap_s, op2_cap_s, op3_cap_s;
    logic [RW-1:0]       rd_cap_s;
    logic [22:0]         inj_roll_s;

    logic                out_valid_d, out_valid_q;
    logic [XLEN-1:0]     op1_d, op1_q, op2_d, op2_q, op3_d, op3_q;
    logic [RW-1:0]       rd_d, rd_q;
    logic [31:0]         out_instr_d, out_instr_q;
    logic                illegal_d, illegal_q;
    logic [NUM_REGS-1:0] sb_d, sb_q;

`ifndef SYNTHESIS
    generate
        if (ERROR_INJECT != 0) begin : g_inject
            logic [22:0] roll_q;
            // Fresh random roll each cycle, consumed by the capture path below.
            always_ff @(posedge clk) begin
                roll_q <= 23'($urandom);
            end
            assign inj_roll_s = roll_q;
        end else begin : g_no_inject
            assign inj_roll_s = 23'd0;
        end
    endgenerate
`else
    assign inj_roll_s = 23'd0;
`endif

    // Decode the offered instruction, detect hazards and resolve forwarding.
    always_comb begin
        r_s         = is_r_type(instr);
        i_s         = is_i_type(instr);
        si_s        = is_si_type(instr);
        s_s         = is_s_type(instr);
        b_s         = is_b_type(instr);
        u_s         = is_u_type(instr);
        j_s         = is_j_type(instr);
        ebreak_s    = is_ebreak(instr);
        illegal_s   = !(r_s | i_s | si_s | s_s | b_s | u_s | j_s | ebreak_s);
        rs1_s       = get_rs1(instr);
        rs2_s       = get_rs2(instr);
        rd_s        = get_rd(instr);
        imm_s       = get_imm(instr);
        uses_rs1_s  = r_s | i_s | si_s | s_s | b_s;
        uses_rs2_s  = r_s | s_s | b_s;
        writes_rd_s = (r_s | i_s | si_s | u_s | j_s) & (rd_s != {RW{1'b0}});
        fwd1_s      = (FORWARDING != 0) & wb_valid & (wb_rd == rs1_s) & (rs1_s != {RW{1'b0}});
        fwd2_s      = (FORWARDING != 0) & wb_valid & (wb_rd == rs2_s) & (rs2_s != {RW{1'b0}});
        rs1_val_s   = fwd1_s ? wb_data : register_bank[int'(rs1_s) * XLEN +: XLEN];
        rs2_val_s   = fwd2_s ? wb_data : register_bank[int'(rs2_s) * XLEN +: XLEN];
        hazard_s    = (uses_rs1_s & sb_q[rs1_s] & !fwd1_s) |
                      (uses_rs2_s & sb_q[rs2_s] & !fwd2_s) |
                      (writes_rd_s & sb_q[rd_s]);
        in_ready_s  = !rst & !flush & (!out_valid_q | out_ready) & !(in_valid & hazard_s);
        accept_s    = in_valid & in_ready_s;
    end

    // Map register values and immediates onto the operand slots for each format.
    always_comb begin
        op1_cap_s = {XLEN{1'b0}};
        op2_cap_s = {XLEN{1'b0}};
        op3_cap_s = {XLEN{1'b0}};
        rd_cap_s  = writes_rd_s ? rd_s : {RW{1'b0}};
        if (r_s) begin
            op1_cap_s = rs1_val_s;
            op2_cap_s = rs2_val_s;
        end else if (i_s | si_s) begin
            op1_cap_s = rs1_val_s;
            op2_cap_s = imm_s;
        end else if (s_s | b_s) begin
            op1_cap_s = rs1_val_s;
            op2_cap_s = rs2_val_s;
            op3_cap_s = imm_s;
        end else if (u_s | j_s) begin
            op1_cap_s = imm_s;
        end else begin
            op1_cap_s = {XLEN{1'b0}};
        end
        // Roughly one capture in ten gets a single bit flipped when injection is on.
        if ((ERROR_INJECT != 0) && (inj_roll_s[22:7] < 16'd6554)) begin
            case (inj_roll_s[6:5])
                2'd0:    op1_cap_s = op1_cap_s ^ (XLEN'(1'b1) << inj_roll_s[4:0]);
                2'd1:    op2_cap_s = op2_cap_s ^ (XLEN'(1'b1) << inj_roll_s[4:0]);
                2'd2:    op3_cap_s = op3_cap_s ^ (XLEN'(1'b1) << inj_roll_s[4:0]);
                default: rd_cap_s  = rd_cap_s ^ (RW'(1'b1) << inj_roll_s[4:0]);
            endcase
        end else begin
            rd_cap_s = rd_cap_s;
        end
    end

    // Output bundle and scoreboard next-state.
    always_comb begin
        out_valid_d = out_valid_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        op3_d       = op3_q;
        rd_d        = rd_q;
        out_instr_d = out_instr_q;
        illegal_d   = illegal_q;
        sb_d        = sb_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept_s) begin
            out_valid_d = 1'b1;
            op1_d       = op1_cap_s;
            op2_d       = op2_cap_s;
            op3_d       = op3_cap_s;
            rd_d        = rd_cap_s;
            out_instr_d = instr;
            illegal_d   = illegal_s;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
        if (wb_valid) begin
            sb_d[wb_rd] = 1'b0;
        end else begin
            sb_d = sb_d;
        end
        // A flushed bundle will never write back, so release its destination.
        if (flush && out_valid_q && (rd_q != {RW{1'b0}})) begin
            sb_d[rd_q] = 1'b0;
        end else begin
            sb_d = sb_d;
        end
        if (accept_s && writes_rd_s) begin
            sb_d[rd_s] = 1'b1;
        end else begin
            sb_d = sb_d;
        end
        sb_d[0] = 1'b0;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            op1_q       <= {XLEN{1'b0}};
            op2_q       <= {XLEN{1'b0}};
            op3_q       <= {XLEN{1'b0}};
            rd_q        <= {RW{1'b0}};
            out_instr_q <= 32'd0;
            illegal_q   <= 1'b0;
            sb_q        <= {NUM_REGS{1'b0}};
        end else begin
            out_valid_q <= out_valid_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            op3_q       <= op3_d;
            rd_q        <= rd_d;
            out_instr_q <= out_instr_d;
            illegal_q   <= illegal_d;
            sb_q        <= sb_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_q;
    assign op1       = op1_q;
    assign op2       = op2_q;
    assign op3       = op3_q;
    assign rd        = rd_q;
    assign out_instr = out_instr_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus a randomized run
// against an instruction-level reference model with its own busy-register table.
module tb_decode_stage;
    localparam int XLEN = 32;
    localparam int NR   = 32;
    localparam int RW   = 5;
    localparam int KILL = 0, KR = 1, KI = 2, KSI = 3, KS = 4, KB = 5, KU = 6, KJ = 7, KEB = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, in_valid, in_valid_nf, flush, out_ready, wb_valid;
    logic [31:0] instr;
    logic [NR*XLEN-1:0] bank;
    logic [RW-1:0] wb_rd;
    logic [XLEN-1:0] wb_data;
    logic in_ready, out_valid, illegal, in_ready_nf, out_valid_nf, illegal_nf;
    logic [XLEN-1:0] op1, op2, op3, op1_nf, op2_nf, op3_nf;
    logic [RW-1:0] rd, rd_nf;
    logic [31:0] out_instr, out_instr_nf;
    int errors = 0;
    int checks = 0;

    decode_stage #(.XLEN(XLEN), .NUM_REGS(NR), .FORWARDING(1), .ERROR_INJECT(0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .register_bank(bank), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .op1(op1), .op2(op2),
        .op3(op3), .rd(rd), .out_instr(out_instr), .illegal(illegal));

    decode_stage #(.XLEN(XLEN), .NUM_REGS(NR), .FORWARDING(0), .ERROR_INJECT(0)) dut_nf (
        .clk(clk), .rst(rst), .in_valid(in_valid_nf), .in_ready(in_ready_nf), .instr(instr),
        .register_bank(bank), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush), .out_valid(out_valid_nf), .out_ready(out_ready), .op1(op1_nf),
        .op2(op2_nf), .op3(op3_nf), .rd(rd_nf), .out_instr(out_instr_nf), .illegal(illegal_nf));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_reg(input int r, input logic [XLEN-1:0] v);
        bank[r*XLEN +: XLEN] = v;
    endtask

    function automatic logic [XLEN-1:0] get_reg(input int r);
        return bank[r*XLEN +: XLEN];
    endfunction

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; in_valid_nf = 1'b0; flush = 1'b0; out_ready = 1'b0;
        wb_valid = 1'b0; wb_rd = '0; wb_data = '0; instr = 32'd0; bank = '0;
        step(); step();
        rst = 1'b0;
    endtask

    // Reference decode: instruction class, register fields and immediate value.
    task automatic model_decode(input logic [31:0] i, output int k, output int r1,
                                output int r2, output int rdn, output logic [31:0] imm);
        logic signed [12:0] bimm;
        logic signed [20:0] jimm;
        r1 = int'(i[19:15]); r2 = int'(i[24:20]); rdn = int'(i[11:7]);
        bimm = {i[31], i[7], i[30:25], i[11:8], 1'b0};
        jimm = {i[31], i[19:12], i[20], i[30:21], 1'b0};
        k = KILL; imm = 32'd0;
        case (int'(i[6:0]))
            'h33: k = KR;
            'h03, 'h67: begin k = KI; imm = 32'($signed(i[31:20])); end
            'h13: begin
                if (i[14:12] == 3'd1 || i[14:12] == 3'd5) begin k = KSI; imm = 32'(i[24:20]); end
                else begin k = KI; imm = 32'($signed(i[31:20])); end
            end
            'h23: begin k = KS; imm = 32'($signed({i[31:25], i[11:7]})); end
            'h63: begin k = KB; imm = 32'(bimm); end
            'h37, 'h17: begin k = KU; imm = {i[31:12], 12'd0}; end
            'h6F: begin k = KJ; imm = 32'(jimm); end
            default: k = (i == 32'h0010_0073) ? KEB : KILL;
        endcase
    endtask

    function automatic logic [31:0] gen_instr();
        logic [4:0] a, b, d;
        logic [2:0] f3;
        logic [31:0] rnd;
        a = 5'($urandom_range(0, 7)); b = 5'($urandom_range(0, 7)); d = 5'($urandom_range(0, 7));
        f3 = 3'($urandom_range(0, 7)); rnd = $urandom;
        case ($urandom_range(0, 9))
            0: return {($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00, b, a, f3, d, 7'h33};
            1: return {rnd[11:0], a, (f3[1:0] == 2'b01) ? 3'b000 : f3, d, 7'h13};
            2: return {($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00, rnd[4:0], a,
                       ($urandom_range(0, 1) != 0) ? 3'b101 : 3'b001, d, 7'h13};
            3: return {rnd[11:0], a, f3, d, 7'h03};
            4: return {rnd[11:0], a, 3'b000, d, 7'h67};
            5: return {rnd[11:5], b, a, f3, rnd[4:0], 7'h23};
            6: return {rnd[11:5], b, a, f3, rnd[4:0], 7'h63};
            7: return {rnd[19:0], d, ($urandom_range(0, 1) != 0) ? 7'h37 : 7'h17};
            8: return {rnd[19:0], d, 7'h6F};
            default: return ($urandom_range(0, 1) != 0) ? 32'h0010_0073
                          : {rnd[24:0], ($urandom_range(0, 1) != 0) ? 7'h7F : 7'h2B};
        endcase
    endfunction

    task automatic test_reset();
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1; instr = 32'h0050_0093;
        step();
        out_ready = 1'b0; instr = 32'h0010_8133;
        step();
        rst = 1'b1;
        step();
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        checks++;
        if ({out_valid, op1, op2, op3, rd, out_instr, illegal} !== '0) begin
            errors++; $display("FAIL reset_outputs: got valid=%b op1=%h op2=%h op3=%h rd=%0d instr=%h ill=%b want all 0",
                               out_valid, op1, op2, op3, rd, out_instr, illegal);
        end
        checks++;
        if (dut.sb_q !== '0) begin errors++; $display("FAIL reset_scoreboard: got %h want 0", dut.sb_q); end
        rst = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_addi_and_forward();
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1; instr = 32'h0050_0093;   // addi x1,x0,5
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL addi_ready: got %b want 1", in_ready); end
        step();
        instr = 32'h0010_8133;                                        // add x2,x1,x1
        checks++;
        if ({out_valid, op1, op2, rd, illegal, dut.sb_q[1]} !== {1'b1, 32'd0, 32'd5, 5'd1, 1'b0, 1'b1}) begin
            errors++; $display("FAIL addi_bundle: got v=%b op1=%h op2=%h rd=%0d ill=%b sb1=%b want 1 0 5 1 0 1",
                               out_valid, op1, op2, rd, illegal, dut.sb_q[1]);
        end
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL raw_stall: got %b want 0", in_ready); end
        step();
        checks++;
        if ({out_valid, in_ready} !== 2'b00) begin
            errors++; $display("FAIL raw_stall_hold: got v=%b rdy=%b want 0 0", out_valid, in_ready);
        end
        wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 32'd5;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL fwd_accept: got %b want 1", in_ready); end
        step();
        wb_valid = 1'b0; in_valid = 1'b0; set_reg(1, 32'd5);
        checks++;
        if ({out_valid, op1, op2, rd, dut.sb_q[2:1]} !== {1'b1, 32'd5, 32'd5, 5'd2, 2'b10}) begin
            errors++; $display("FAIL fwd_bundle: got v=%b op1=%h op2=%h rd=%0d sb=%b want 1 5 5 2 10",
                               out_valid, op1, op2, rd, dut.sb_q[2:1]);
        end
    endtask

    task automatic test_no_forward();
        do_reset();
        out_ready = 1'b1; in_valid_nf = 1'b1; instr = 32'h0050_0093;
        step();
        instr = 32'h0010_8133;
        wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 32'd5;
        #1;
        checks++;
        if (in_ready_nf !== 1'b0) begin errors++; $display("FAIL nofwd_stall_in_wb_cycle: got %b want 0", in_ready_nf); end
        step();
        wb_valid = 1'b0; set_reg(1, 32'd5);
        #1;
        checks++;
        if (in_ready_nf !== 1'b1) begin errors++; $display("FAIL nofwd_accept_after_wb: got %b want 1", in_ready_nf); end
        step();
        in_valid_nf = 1'b0;
        checks++;
        if ({out_valid_nf, op1_nf, op2_nf, rd_nf} !== {1'b1, 32'd5, 32'd5, 5'd2}) begin
            errors++; $display("FAIL nofwd_bundle: got v=%b op1=%h op2=%h rd=%0d want 1 5 5 2",
                               out_valid_nf, op1_nf, op2_nf, rd_nf);
        end
    endtask

    task automatic test_store();
        do_reset();
        set_reg(1, 32'hAA); set_reg(2, 32'h100);
        out_ready = 1'b1; in_valid = 1'b1; instr = 32'h0011_2023;   // sw x1,0(x2): rs1=x2, rs2=x1
        step();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, op1, op2, op3, rd, dut.sb_q} !== {1'b1, 32'h100, 32'hAA, 32'd0, 5'd0, 32'd0}) begin
            errors++; $display("FAIL store_bundle: got v=%b op1=%h op2=%h op3=%h rd=%0d sb=%h want 1 100 aa 0 0 0",
                               out_valid, op1, op2, op3, rd, dut.sb_q);
        end
    endtask

    task automatic test_hold();
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1; instr = 32'h0050_0093;
        step();
        out_ready = 1'b0; instr = 32'h0000_52B7;                      // lui x5,5
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if ({in_ready, out_valid, op1, op2, op3, rd, out_instr} !==
                {1'b0, 1'b1, 32'd0, 32'd5, 32'd0, 5'd1, 32'h0050_0093}) begin
                errors++; $display("FAIL hold_stable[%0d]: got rdy=%b v=%b op1=%h op2=%h op3=%h rd=%0d instr=%h",
                                   k, in_ready, out_valid, op1, op2, op3, rd, out_instr);
            end
            step();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL hold_release_ready: got %b want 1", in_ready); end
        step();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, op1, rd} !== {1'b1, 32'h5000, 5'd5}) begin
            errors++; $display("FAIL hold_next_bundle: got v=%b op1=%h rd=%0d want 1 5000 5", out_valid, op1, rd);
        end
    endtask

    task automatic test_illegal_ebreak();
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1; instr = 32'hFFFF_FFFF;
        step();
        instr = 32'h0010_0073;
        checks++;
        if ({out_valid, illegal, op1, op2, op3, rd, dut.sb_q} !== {2'b11, 96'd0, 5'd0, 32'd0}) begin
            errors++; $display("FAIL illegal_bundle: got v=%b ill=%b op1=%h op2=%h op3=%h rd=%0d sb=%h",
                               out_valid, illegal, op1, op2, op3, rd, dut.sb_q);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, illegal, op1, op2, op3, rd} !== {2'b10, 96'd0, 5'd0}) begin
            errors++; $display("FAIL ebreak_bundle: got v=%b ill=%b op1=%h op2=%h op3=%h rd=%0d",
                               out_valid, illegal, op1, op2, op3, rd);
        end
    endtask

    task automatic test_flush();
        do_reset();
        set_reg(3, 32'h77);
        out_ready = 1'b1; in_valid = 1'b1; instr = 32'h0070_0193;   // addi x3,x0,7
        step();
        out_ready = 1'b0; flush = 1'b1; instr = 32'h0031_8233;      // add x4,x3,x3
        checks++;
        if (dut.sb_q[3] !== 1'b1) begin errors++; $display("FAIL flush_pre_sb3: got %b want 1", dut.sb_q[3]); end
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_blocks_accept: got %b want 0", in_ready); end
        step();
        flush = 1'b0;
        checks++;
        if ({out_valid, dut.sb_q[3]} !== 2'b00) begin
            errors++; $display("FAIL flush_effect: got v=%b sb3=%b want 0 0", out_valid, dut.sb_q[3]);
        end
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_then_accept: got %b want 1", in_ready); end
        step();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, op1, op2, rd, dut.sb_q[4]} !== {1'b1, 32'h77, 32'h77, 5'd4, 1'b1}) begin
            errors++; $display("FAIL flush_next_bundle: got v=%b op1=%h op2=%h rd=%0d sb4=%b want 1 77 77 4 1",
                               out_valid, op1, op2, rd, dut.sb_q[4]);
        end
    endtask

    task automatic test_random();
        logic m_valid, m_ill, acc, exp_ready, haz, f1, f2, u1, u2, wr;
        logic [XLEN-1:0] m_op1, m_op2, m_op3, v1, v2;
        logic [31:0] m_instr, imm;
        int m_rd, k, r1, r2, rdn;
        bit busy[NR];
        int cand[$];
        do_reset();
        for (int r = 1; r < 8; r++) set_reg(r, $urandom);
        m_valid = 1'b0; m_ill = 1'b0; m_op1 = '0; m_op2 = '0; m_op3 = '0; m_instr = '0; m_rd = 0;
        foreach (busy[r]) busy[r] = 1'b0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            checks++;
            if (out_valid !== m_valid) begin
                errors++; $display("FAIL rand_valid[%0d]: got %b want %b", cyc, out_valid, m_valid);
            end
            if (m_valid) begin
                checks++;
                if ({op1, op2, op3, rd, out_instr, illegal} !== {m_op1, m_op2, m_op3, 5'(m_rd), m_instr, m_ill}) begin
                    errors++; $display("FAIL rand_bundle[%0d]: got %h %h %h rd=%0d %h ill=%b want %h %h %h rd=%0d %h ill=%b",
                        cyc, op1, op2, op3, rd, out_instr, illegal, m_op1, m_op2, m_op3, m_rd, m_instr, m_ill);
                end
            end
            in_valid = ($urandom_range(0, 3) != 0);
            instr = gen_instr();
            out_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 19) == 0);
            wb_valid = ($urandom_range(0, 2) == 0);
            wb_data = $urandom;
            cand.delete();
            for (int r = 1; r < 8; r++) if (busy[r]) cand.push_back(r);
            if (cand.size() > 0 && $urandom_range(0, 3) != 0) wb_rd = 5'(cand[$urandom_range(0, cand.size() - 1)]);
            else wb_rd = 5'($urandom_range(0, 7));
            #1;
            model_decode(instr, k, r1, r2, rdn, imm);
            u1 = (k == KR || k == KI || k == KSI || k == KS || k == KB);
            u2 = (k == KR || k == KS || k == KB);
            wr = (k == KR || k == KI || k == KSI || k == KU || k == KJ) && rdn != 0;
            f1 = wb_valid && int'(wb_rd) == r1 && r1 != 0;
            f2 = wb_valid && int'(wb_rd) == r2 && r2 != 0;
            v1 = f1 ? wb_data : get_reg(r1);
            v2 = f2 ? wb_data : get_reg(r2);
            haz = (u1 && busy[r1] && !f1) || (u2 && busy[r2] && !f2) || (wr && busy[rdn]);
            exp_ready = !flush && (!m_valid || out_ready) && !(in_valid && haz);
            checks++;
            if (in_ready !== exp_ready) begin
                errors++; $display("FAIL rand_in_ready[%0d]: got %b want %b instr=%h", cyc, in_ready, exp_ready, instr);
            end
            acc = in_valid && exp_ready;
            if (wb_valid) busy[wb_rd] = 1'b0;
            if (flush && m_valid && m_rd != 0) busy[m_rd] = 1'b0;
            if (acc && wr) busy[rdn] = 1'b1;
            if (flush) m_valid = 1'b0;
            else if (acc) begin
                m_valid = 1'b1; m_instr = instr; m_ill = (k == KILL); m_rd = wr ? rdn : 0;
                m_op1 = '0; m_op2 = '0; m_op3 = '0;
                case (k)
                    KR:      begin m_op1 = v1; m_op2 = v2; end
                    KI, KSI: begin m_op1 = v1; m_op2 = imm; end
                    KS, KB:  begin m_op1 = v1; m_op2 = v2; m_op3 = imm; end
                    KU, KJ:  m_op1 = imm;
                    default: m_op1 = '0;
                endcase
            end else if (out_ready) m_valid = 1'b0;
            step();
            if (wb_valid && wb_rd != 0) set_reg(int'(wb_rd), wb_data);
        end
        in_valid = 1'b0; flush = 1'b0; wb_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_addi_and_forward();
        test_no_forward();
        test_store();
        test_hold();
        test_illegal_ebreak();
        test_flush();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
